ula_ncl_sequencer: RTL and testbench
====================================

# ula_ncl_sequencer

Clocked controller that shares the dual-rail NCL ALU (`ULA`) between two synchronous requesters. It arbitrates round-robin and encodes the winning binary operation into a DATA wavefront. It then synchronises the ALU's completion, captures and decodes the result, returns the ALU to NULL and delivers a binary response over a valid/ready handshake. It sits between the synchronous pipeline and the asynchronous `ULA` instance.

## Interface
- `SYNC_STAGES`, 2: flops in each completion synchroniser (≥2).
- `TIMEOUT`, 255: max cycles spent in DATA_WAIT or NULL_WAIT before error (1..255, 8-bit counter).
- `clk`  in  1  clock; all flops rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low).
- `r0_valid`, `r1_valid`  in  1  request valid.
- `r0_ready`, `r1_ready`  out  1  request accepted this cycle.
- `r0_op`, `r1_op`  in  2  00 ADD, 01 SUB, 10 XOR, 11 OR.
- `r0_a`, `r0_b`, `r1_a`, `r1_b`  in  5  two's-complement operands.
- `r0_cin`, `r1_cin`  in  1  carry-in.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_id`  out  1  requester index.
- `rsp_out`  out  5  result.
- `rsp_ovf`, `rsp_neg`, `rsp_zero`, `rsp_err`  out  1  flags / error.
- `busy`  out  1  state ≠ IDLE.
- `ula_a`, `ula_b`  out  10  dual-rail operands to ALU.
- `ula_sel0`, `ula_sel1`, `ula_cin`  out  2  dual-rail controls.
- `ula_out`  in  10; `ula_ovf`, `ula_neg`, `ula_zero`  in  2  dual-rail ALU outputs (asynchronous).

## Operation
- Dual-rail code per bit: 00 NULL, 01 logic 0, 10 logic 1, 11 illegal. Bit k of a vector maps to pair [2k+1:2k].
- Op encoding: `sel1` = op[1], `sel0` = op[0]. ADD gives {Sel1,Sel0}=0101, SUB 0110, XOR 1001, OR 1010. No other combination is ever driven.
- All `ula_*` outputs are registered. They are NULL (all zero) in every state except DATA_WAIT.
- `comp_raw`: all 8 output pairs ≠ 00. `null_raw`: all 8 pairs = 00. Each goes through its own SYNC_STAGES-flop synchroniser, which resets to 0, giving `comp_sync` and `null_sync`.
- Arbiter: the `last` flop resets to 1, so r0 wins the first contention. When both requesters are valid, the one ≠ `last` wins. `last` updates on grant.
- States:
  - IDLE: if any request is valid, assert the winner's `rX_ready` combinationally. Latch op/a/b/cin/id, clear timer, go DATA_WAIT.
  - DATA_WAIT: drive encoded DATA. On `comp_sync`, capture the decoded pairs into the response regs. `rsp_err` = any pair 11. Go NULL_WAIT. On timer = TIMEOUT with no completion: set err, zero the result fields, go NULL_WAIT.
  - NULL_WAIT: drive NULL, clear timer on entry. On `null_sync`, go RESP. On timer = TIMEOUT: set err, go RESP.
  - RESP: `rsp_valid` = 1. Payload is held stable until `rsp_valid && rsp_ready`, then go IDLE. No request is accepted while in RESP.
- `rX_ready` is never asserted outside IDLE and never for both requesters in the same cycle.
- Decode: pair 10 gives 1; 01 or 11 gives 0, with err set for 11. The sequencer does not recompute flags; it reports the ALU's own.
- Reset values:
  - `ula_*` = 0 (NULL).
  - State IDLE, timer 0, synchronisers 0, `last` = 1.
  - `rsp_*` = 0, `rX_ready` = 0, `busy` = 0.
- Reset mid-operation: ALU inputs return to NULL immediately and asynchronously, and any pending response is discarded.

## Timing
- Accept at cycle T. DATA appears on `ula_*` at T+1.
- With an instantaneous ALU: `comp_sync` is high at T+1+SYNC_STAGES, with capture at the end of that cycle. NULL is driven from T+2+SYNC_STAGES.
- `rsp_valid` is first high at T+3+2·SYNC_STAGES, which is T+7 at the default.
- ALU delay adds directly to the latency.
- Throughput is one operation per (2·SYNC_STAGES+4) cycles minimum, including the IDLE cycle after the handshake.
- The timer counts cycles in the current wait state. Timeout fires when the timer reaches TIMEOUT.
- A response handshake at cycle R allows acceptance of a new request at R+1 at the earliest.

## Test plan
- ADD, r0: a=7, b=7, cin=0, with a zero-delay `ULA` → `ula_a`=0101101010 at T+1. Response at T+7: out=01110, ovf=0, neg=0, zero=0, err=0, id=0.
- SUB, r1: a=10, b=11, cin=1 → `ula_sel0`=10, `ula_sel1`=01. Result out=11111, neg=1, zero=0, ovf=0, id=1.
- Both requesters valid for 3 operations (r0 XOR 8^12, r1 OR 9|6) → grant order r0, r1, r0. Results 00100 then 01111. `rsp_ready` is held low for 5 cycles and the payload must stay stable throughout.
- ALU model never completes → err=1 and out=0. DATA is held exactly TIMEOUT+1 cycles after entry, then NULL is driven. Next request is served normally.
- ALU model returns `ula_neg`=11 → err=1; the other fields are decoded.
- `rst_n` pulsed low during DATA_WAIT → `ula_*`=0 asynchronously, with `rsp_valid`=0 and `busy`=0. The first request after release is granted to r0.

Source files
------------

// File: rtl/ula_ncl_sequencer_if.sv
// Request/response bundle between the synchronous pipeline
// and the shared NCL ALU sequencer.
interface ula_ncl_sequencer_if;
    logic       r0_valid;
    logic       r0_ready;
    logic [1:0] r0_op;
    logic [4:0] r0_a;
    logic [4:0] r0_b;
    logic       r0_cin;
    logic       r1_valid;
    logic       r1_ready;
    logic [1:0] r1_op;
    logic [4:0] r1_a;
    logic [4:0] r1_b;
    logic       r1_cin;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [4:0] rsp_out;
    logic       rsp_ovf;
    logic       rsp_neg;
    logic       rsp_zero;
    logic       rsp_err;

    modport master (
        output r0_valid, r0_op, r0_a, r0_b, r0_cin,
        output r1_valid, r1_op, r1_a, r1_b, r1_cin,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_out,
        input  rsp_ovf, rsp_neg, rsp_zero, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b, r0_cin,
        input  r1_valid, r1_op, r1_a, r1_b, r1_cin,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_out,
        output rsp_ovf, rsp_neg, rsp_zero, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/ula_ncl_sequencer.sv
// Round-robin sequencer sharing one dual-rail NCL ALU between two
// synchronous requesters: encode DATA, sync completion, decode, NULL.
module ula_ncl_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ula_ncl_sequencer_if.slave   bus,
    output logic                 busy,
    output logic [9:0]           ula_a,
    output logic [9:0]           ula_b,
    output logic [1:0]           ula_sel0,
    output logic [1:0]           ula_sel1,
    output logic [1:0]           ula_cin,
    input  logic [9:0]           ula_out,
    input  logic [1:0]           ula_ovf,
    input  logic [1:0]           ula_neg,
    input  logic [1:0]           ula_zero
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DATA_WAIT = 2'd1;
    localparam logic [1:0] NULL_WAIT = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [1:0] state;
    logic [7:0] timer;
    logic       last;
    logic       id_q;

    logic       rsp_id_q;
    logic [4:0] rsp_out_q;
    logic       rsp_ovf_q;
    logic       rsp_neg_q;
    logic       rsp_zero_q;
    logic       rsp_err_q;

    logic [SYNC_STAGES-1:0] comp_ff;
    logic [SYNC_STAGES-1:0] null_ff;
    logic                   comp_sync;
    logic                   null_sync;

    logic        comp_raw;
    logic        null_raw;
    logic        bad_pair;
    logic [15:0] pairs;
    logic [4:0]  dec_out;
    logic        dec_ovf;
    logic        dec_neg;
    logic        dec_zero;

    logic       win1;
    logic       accept;
    logic [1:0] sel_op;
    logic [4:0] sel_a;
    logic [4:0] sel_b;
    logic       sel_cin;

    function automatic logic [1:0] enc1(input logic v);
        return v ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [9:0] enc5(input logic [4:0] v);
        logic [9:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[2*k +: 2] = enc1(v[k]);
        end
        return r;
    endfunction

    function automatic logic dec1(input logic [1:0] p);
        return p == 2'b10;
    endfunction

    // Both valid: the requester not granted last time wins.
    assign win1   = bus.r1_valid && (!bus.r0_valid || !last);
    assign accept = rst_n && (state == IDLE) &&
                    (bus.r0_valid || bus.r1_valid);

    assign bus.r0_ready = accept && !win1;
    assign bus.r1_ready = accept && win1;

    assign sel_op  = win1 ? bus.r1_op  : bus.r0_op;
    assign sel_a   = win1 ? bus.r1_a   : bus.r0_a;
    assign sel_b   = win1 ? bus.r1_b   : bus.r0_b;
    assign sel_cin = win1 ? bus.r1_cin : bus.r0_cin;

    assign pairs = {ula_zero, ula_neg, ula_ovf, ula_out};

    always_comb begin
        comp_raw = 1'b1;
        null_raw = 1'b1;
        bad_pair = 1'b0;
        dec_out  = '0;
        for (int k = 0; k < 8; k++) begin
            if (pairs[2*k +: 2] == 2'b00) begin
                comp_raw = 1'b0;
            end else begin
                null_raw = 1'b0;
            end
            if (pairs[2*k +: 2] == 2'b11) begin
                bad_pair = 1'b1;
            end
        end
        for (int k = 0; k < 5; k++) begin
            dec_out[k] = dec1(ula_out[2*k +: 2]);
        end
    end

    assign dec_ovf  = dec1(ula_ovf);
    assign dec_neg  = dec1(ula_neg);
    assign dec_zero = dec1(ula_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_ff <= '0;
            null_ff <= '0;
        end else begin
            comp_ff <= {comp_ff[SYNC_STAGES-2:0], comp_raw};
            null_ff <= {null_ff[SYNC_STAGES-2:0], null_raw};
        end
    end

    assign comp_sync = comp_ff[SYNC_STAGES-1];
    assign null_sync = null_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            last       <= 1'b1;
            id_q       <= 1'b0;
            ula_a      <= '0;
            ula_b      <= '0;
            ula_sel0   <= '0;
            ula_sel1   <= '0;
            ula_cin    <= '0;
            rsp_id_q   <= 1'b0;
            rsp_out_q  <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_neg_q  <= 1'b0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ula_a    <= enc5(sel_a);
                        ula_b    <= enc5(sel_b);
                        ula_sel0 <= enc1(sel_op[0]);
                        ula_sel1 <= enc1(sel_op[1]);
                        ula_cin  <= enc1(sel_cin);
                        id_q     <= win1;
                        last     <= win1;
                        timer    <= '0;
                        state    <= DATA_WAIT;
                    end
                end
                DATA_WAIT: begin
                    if (comp_sync || timer == TMO) begin
                        ula_a    <= '0;
                        ula_b    <= '0;
                        ula_sel0 <= '0;
                        ula_sel1 <= '0;
                        ula_cin  <= '0;
                        timer    <= '0;
                        rsp_id_q <= id_q;
                        state    <= NULL_WAIT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                    // Completion has priority over a coincident timeout.
                    if (comp_sync) begin
                        rsp_out_q  <= dec_out;
                        rsp_ovf_q  <= dec_ovf;
                        rsp_neg_q  <= dec_neg;
                        rsp_zero_q <= dec_zero;
                        rsp_err_q  <= bad_pair;
                    end else if (timer == TMO) begin
                        rsp_out_q  <= '0;
                        rsp_ovf_q  <= 1'b0;
                        rsp_neg_q  <= 1'b0;
                        rsp_zero_q <= 1'b0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                NULL_WAIT: begin
                    if (null_sync) begin
                        state <= RESP;
                    end else if (timer == TMO) begin
                        rsp_err_q <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.rsp_neg   = rsp_neg_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ula_ncl_sequencer.sv
// Bench for ula_ncl_sequencer: zero-delay dual-rail ALU model plus
// an integer-arithmetic reference for expected responses.
`timescale 1ns/1ps
module tb_ula_ncl_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ula_ncl_sequencer_if bus();

    logic       busy;
    logic [9:0] ula_a;
    logic [9:0] ula_b;
    logic [1:0] ula_sel0;
    logic [1:0] ula_sel1;
    logic [1:0] ula_cin;
    logic [9:0] ula_out;
    logic [1:0] ula_ovf;
    logic [1:0] ula_neg;
    logic [1:0] ula_zero;

    int total = 0;
    int bad = 0;
    int alu_mode = 0;

    logic [9:0] pay;
    assign pay = {bus.rsp_id, bus.rsp_out, bus.rsp_ovf,
                  bus.rsp_neg, bus.rsp_zero, bus.rsp_err};

    ula_ncl_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .busy     (busy),
        .ula_a    (ula_a),
        .ula_b    (ula_b),
        .ula_sel0 (ula_sel0),
        .ula_sel1 (ula_sel1),
        .ula_cin  (ula_cin),
        .ula_out  (ula_out),
        .ula_ovf  (ula_ovf),
        .ula_neg  (ula_neg),
        .ula_zero (ula_zero)
    );

    function automatic logic all_data(input logic [25:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (v[2*k +: 2] != 2'b01 && v[2*k +: 2] != 2'b10) ok = 1'b0;
        end
        return ok;
    endfunction

    // Dual-rail ALU stand-in; alu_mode 1 never completes, 2 drives neg=11.
    logic [4:0] m_a, m_b, m_bb, m_o;
    logic [5:0] m_s;
    logic       m_v;
    always_comb begin
        ula_out = '0; ula_ovf = '0; ula_neg = '0; ula_zero = '0;
        m_a = '0; m_b = '0; m_bb = '0; m_o = '0; m_s = '0; m_v = 1'b0;
        if (alu_mode != 1 &&
            all_data({ula_a, ula_b, ula_sel0, ula_sel1, ula_cin})) begin
            for (int k = 0; k < 5; k++) begin
                m_a[k] = ula_a[2*k+1];
                m_b[k] = ula_b[2*k+1];
            end
            m_bb = ula_sel0[1] ? ~m_b : m_b;
            if (!ula_sel1[1]) begin
                m_s = {1'b0, m_a} + {1'b0, m_bb} + {5'b0, ula_cin[1]};
                m_o = m_s[4:0];
                m_v = (m_a[4] == m_bb[4]) && (m_o[4] != m_a[4]);
            end else if (!ula_sel0[1]) begin
                m_o = m_a ^ m_b;
            end else begin
                m_o = m_a | m_b;
            end
            for (int k = 0; k < 5; k++) begin
                ula_out[2*k +: 2] = m_o[k] ? 2'b10 : 2'b01;
            end
            ula_ovf  = m_v ? 2'b10 : 2'b01;
            ula_neg  = m_o[4] ? 2'b10 : 2'b01;
            ula_zero = (m_o == 5'd0) ? 2'b10 : 2'b01;
            if (alu_mode == 2) ula_neg = 2'b11;
        end
    end

    // Returns {out, ovf, neg, zero}.
    function automatic logic [7:0] ref_alu(input logic [1:0] op,
        input logic [4:0] a, input logic [4:0] b, input logic cin);
        int sa, sb, c, r;
        logic [4:0] o;
        logic ov;
        sa = $signed(a); sb = $signed(b); c = cin; ov = 1'b0; r = 0;
        case (op)
            2'd0:    r = sa + sb + c;
            2'd1:    r = sa - sb - 1 + c;
            2'd2:    r = a ^ b;
            default: r = a | b;
        endcase
        if (op < 2'd2) ov = (r > 15) || (r < -16);
        o = r[4:0];
        return {o, ov, o[4], o == 5'd0};
    endfunction

    task automatic do_reset();
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0; bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_r0(input logic [1:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic cin);
        bus.r0_op = op; bus.r0_a = a; bus.r0_b = b; bus.r0_cin = cin;
    endtask

    task automatic set_r1(input logic [1:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic cin);
        bus.r1_op = op; bus.r1_a = a; bus.r1_b = b; bus.r1_cin = cin;
    endtask

    // Returns at accept-cycle+1 (+1ns); who = -1 when nothing was granted.
    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.r0_ready && bus.r1_ready) begin who = 3; break; end
            if (bus.r0_ready) begin who = 0; break; end
            if (bus.r1_ready) begin who = 1; break; end
            @(posedge clk); #1;
        end
        if (who >= 0) begin @(posedge clk); #1; end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 700) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.r0_valid = 1'b1;
        #1;
        total++;
        if (bus.r0_ready !== 1'b0) begin
            bad++; $display("FAIL ready_in_reset: got %b want 0", bus.r0_ready);
        end
        do_reset();
        #1;
        total++;
        if ({ula_a, ula_b, ula_sel0, ula_sel1, ula_cin} !== 26'd0) begin
            bad++; $display("FAIL reset_ula: got %h want 0", ula_a);
        end
        total++;
        if ({busy, bus.rsp_valid} !== 2'b00) begin
            bad++; $display("FAIL reset_busy: got %b%b want 00", busy, bus.rsp_valid);
        end
        total++;
        if (pay !== 10'd0) begin
            bad++; $display("FAIL reset_payload: got %b want 0", pay);
        end
        total++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b%b want 00", bus.r0_ready, bus.r1_ready);
        end
    endtask

    task automatic test_add();
        int who, lat;
        set_r0(2'd0, 5'd7, 5'd7, 1'b0);
        bus.r0_valid = 1'b1;
        wait_grant(who);
        bus.r0_valid = 1'b0;
        total++;
        if (who !== 0) begin bad++; $display("FAIL add_grant: got %0d want 0", who); end
        total++;
        if (ula_a !== 10'b0101101010) begin
            bad++; $display("FAIL add_ula_a: got %b want 0101101010", ula_a);
        end
        wait_rsp(lat);
        total++;
        if (lat !== 6) begin bad++; $display("FAIL add_latency: got T+%0d want T+7", lat + 1); end
        total++;
        if (pay !== {1'b0, 5'b01110, 4'b0000}) begin
            bad++; $display("FAIL add_payload: got %b want 0011100000", pay);
        end
        handshake();
    endtask

    task automatic test_sub();
        int who, lat;
        set_r1(2'd1, 5'd10, 5'd11, 1'b1);
        bus.r1_valid = 1'b1;
        wait_grant(who);
        bus.r1_valid = 1'b0;
        total++;
        if ({ula_sel0, ula_sel1} !== 4'b1001 || who !== 1) begin
            bad++; $display("FAIL sub_sel: got %b%b who %0d want 1001 who 1", ula_sel0, ula_sel1, who);
        end
        wait_rsp(lat);
        total++;
        if (pay !== {1'b1, 5'b11111, 4'b0100}) begin
            bad++; $display("FAIL sub_payload: got %b want 1111110100", pay);
        end
        handshake();
    endtask

    task automatic test_arbitration();
        int who, lat, n0;
        int exp_who[3] = '{0, 1, 0};
        logic [9:0] snap, expp;
        do_reset();
        set_r0(2'd2, 5'd8, 5'd12, 1'b0);
        set_r1(2'd3, 5'd9, 5'd6, 1'b0);
        bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
        n0 = 0;
        for (int i = 0; i < 3; i++) begin
            wait_grant(who);
            total++;
            if (who !== exp_who[i]) begin
                bad++; $display("FAIL arb_order%0d: got %0d want %0d", i, who, exp_who[i]);
            end
            if (who == 0) begin
                n0++;
                if (n0 == 2) bus.r0_valid = 1'b0;
            end else begin
                bus.r1_valid = 1'b0;
            end
            wait_rsp(lat);
            expp = (exp_who[i] == 0) ? {1'b0, 5'b00100, 4'b0000}
                                     : {1'b1, 5'b01111, 4'b0000};
            total++;
            if (pay !== expp || bus.rsp_valid !== 1'b1) begin
                bad++; $display("FAIL arb_payload%0d: got %b want %b", i, pay, expp);
            end
            snap = pay;
            for (int j = 0; j < 5; j++) begin
                @(posedge clk); #1;
                total++;
                if ({bus.rsp_valid, pay, bus.r0_ready, bus.r1_ready} !== {1'b1, snap, 2'b00}) begin
                    bad++; $display("FAIL arb_hold%0d: got %b want %b", j, pay, snap);
                end
            end
            handshake();
        end
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int who, lat, cnt;
        alu_mode = 1;
        set_r0(2'd0, 5'd3, 5'd4, 1'b0);
        bus.r0_valid = 1'b1;
        wait_grant(who);
        bus.r0_valid = 1'b0;
        cnt = 0;
        while (ula_a !== 10'd0 && cnt < 400) begin
            cnt++; @(posedge clk); #1;
        end
        total++;
        if (cnt !== 256) begin bad++; $display("FAIL tmo_data_cycles: got %0d want 256", cnt); end
        wait_rsp(lat);
        total++;
        if (pay !== {1'b0, 5'b0, 4'b0001} || bus.rsp_valid !== 1'b1) begin
            bad++; $display("FAIL tmo_payload: got %b want 0000000001", pay);
        end
        handshake();
        alu_mode = 0;
        set_r1(2'd2, 5'd5, 5'd3, 1'b0);
        bus.r1_valid = 1'b1;
        wait_grant(who);
        bus.r1_valid = 1'b0;
        wait_rsp(lat);
        total++;
        if (pay !== {1'b1, ref_alu(2'd2, 5'd5, 5'd3, 1'b0), 1'b0}) begin
            bad++; $display("FAIL tmo_recover: got %b want 1001100000", pay);
        end
        handshake();
    endtask

    task automatic test_illegal_neg();
        int who, lat;
        logic [7:0] r;
        alu_mode = 2;
        set_r0(2'd0, 5'b11101, 5'd1, 1'b0);
        bus.r0_valid = 1'b1;
        wait_grant(who);
        bus.r0_valid = 1'b0;
        wait_rsp(lat);
        r = ref_alu(2'd0, 5'b11101, 5'd1, 1'b0);
        total++;
        if (pay !== {1'b0, r[7:3], r[2], 1'b0, r[0], 1'b1}) begin
            bad++; $display("FAIL illegal_neg: got %b want %b", pay, {1'b0, r[7:3], r[2], 1'b0, r[0], 1'b1});
        end
        handshake();
        alu_mode = 0;
    endtask

    task automatic test_back_to_back();
        int who, lat;
        set_r0(2'd3, 5'd1, 5'd2, 1'b0);
        set_r1(2'd0, 5'd2, 5'd2, 1'b1);
        bus.r0_valid = 1'b1;
        wait_grant(who);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b1;
        wait_rsp(lat);
        handshake();
        total++;
        if (bus.r1_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_ready: got %b want 1", bus.r1_ready);
        end
        wait_grant(who);
        bus.r1_valid = 1'b0;
        wait_rsp(lat);
        total++;
        if (pay !== {1'b1, ref_alu(2'd0, 5'd2, 5'd2, 1'b1), 1'b0}) begin
            bad++; $display("FAIL b2b_payload: got %b", pay);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int who, lat;
        set_r0(2'd0, 5'd1, 5'd2, 1'b0);
        bus.r0_valid = 1'b1;
        wait_grant(who);
        bus.r0_valid = 1'b0;
        total++;
        if (ula_a === 10'd0) begin bad++; $display("FAIL mid_data: got %h want nonzero", ula_a); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ula_a, ula_b, ula_sel0, ula_sel1, ula_cin} !== 26'd0) begin
            bad++; $display("FAIL mid_async_null: got %h want 0", ula_a);
        end
        total++;
        if ({busy, bus.rsp_valid} !== 2'b00) begin
            bad++; $display("FAIL mid_busy: got %b%b want 00", busy, bus.rsp_valid);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        set_r0(2'd0, 5'd2, 5'd3, 1'b0);
        set_r1(2'd3, 5'd4, 5'd1, 1'b0);
        bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
        wait_grant(who);
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        total++;
        if (who !== 0) begin bad++; $display("FAIL mid_first_grant: got %0d want 0", who); end
        wait_rsp(lat);
        total++;
        if (pay !== {1'b0, ref_alu(2'd0, 5'd2, 5'd3, 1'b0), 1'b0}) begin
            bad++; $display("FAIL mid_payload: got %b", pay);
        end
        handshake();
    endtask

    task automatic test_random();
        int who, lat, pick, ew;
        logic last_id;
        logic [1:0] op0, op1;
        logic [4:0] a0, b0, a1, b1;
        logic c0, c1;
        logic [9:0] expp;
        do_reset();
        last_id = 1'b1;
        for (int n = 0; n < 24; n++) begin
            op0 = 2'($urandom_range(0, 3)); a0 = 5'($urandom); b0 = 5'($urandom);
            op1 = 2'($urandom_range(0, 3)); a1 = 5'($urandom); b1 = 5'($urandom);
            c0 = 1'($urandom); c1 = 1'($urandom);
            pick = $urandom_range(0, 2);
            set_r0(op0, a0, b0, c0);
            set_r1(op1, a1, b1, c1);
            bus.r0_valid = (pick != 1);
            bus.r1_valid = (pick != 0);
            ew = (pick == 2) ? int'(!last_id) : ((pick == 1) ? 1 : 0);
            wait_grant(who);
            bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
            total++;
            if (who !== ew) begin bad++; $display("FAIL rnd_grant%0d: got %0d want %0d", n, who, ew); end
            last_id = (ew == 1);
            expp = (ew == 1) ? {1'b1, ref_alu(op1, a1, b1, c1), 1'b0}
                             : {1'b0, ref_alu(op0, a0, b0, c0), 1'b0};
            wait_rsp(lat);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            total++;
            if (pay !== expp || bus.rsp_valid !== 1'b1) begin
                bad++; $display("FAIL rnd_payload%0d: got %b want %b", n, pay, expp);
            end
            handshake();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0; bus.rsp_ready = 1'b0;
        set_r0(2'd0, 5'd0, 5'd0, 1'b0);
        set_r1(2'd0, 5'd0, 5'd0, 1'b0);
        test_reset();
        test_add();
        test_sub();
        test_arbitration();
        test_timeout();
        test_illegal_neg();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
